bcd_accumulator: RTL and testbench
==================================

// Module: bcd_accumulator
// PURPOSE
//  Upstream operand stage for the BCD adder/display path: takes one BCD digit per
//  debounced pushbutton press and accumulates a two-digit BCD running total (00..99).
//  Ones/Tens feed the hex_disp decoders directly; Ovf/Err drive LEDs.
//  Sequential: button synchronizer, debounce filter, press-edge detect, 4-state FSM.
// PARAMETERS
//  DB_CYCLES  500000  stable-level cycles before the debounced button changes (10 ms @ 50 MHz)
//  DB_W       19      debounce counter width; must satisfy 2**DB_W > DB_CYCLES
// PORTS
//  Clock   in   1  system clock, single clock domain, rising edge
//  Resetn  in   1  asynchronous, active-low reset
//  Digit   in   4  BCD operand from switches; legal range 0..9
//  Cin     in   1  extra +1 added with Digit
//  Add_n   in   1  pushbutton, active-low, asynchronous to Clock, bouncy
//  Clr     in   1  synchronous clear, level sensitive, active-high
//  Ones    out  4  BCD ones digit of the total
//  Tens    out  4  BCD tens digit of the total
//  Ovf     out  1  sticky: total wrapped past 99
//  Err     out  1  sticky: press seen with Digit > 9
//  Busy    out  1  high whenever FSM is not IDLE
//  Done    out  1  one-cycle pulse when a new total is visible
// BEHAVIOUR
//  Reset (async, Resetn=0): Ones=Tens=0, Ovf=Err=Busy=Done=0, FSM=IDLE,
//    both sync flops=1, debounced level=1, debounce counter=0, operand regs=0.
//  Sync: two flops on Add_n. Filter: counter increments while synced != debounced,
//    clears when equal; reaching DB_CYCLES-1 flips debounced and clears counter.
//  Press = debounced 1->0 transition, registered single-cycle pulse.
//  FSM IDLE: on press, if Digit>9 -> Err<=1, go WAIT_REL, totals unchanged;
//    else latch Digit,Cin into operand regs, go ONES.
//  ONES: s = Ones + D + C (5-bit, max 19); if s>9 Ones<=s-10, carry<=1,
//    else Ones<=s, carry<=0. Go TENS.
//  TENS: t = Tens + carry; if t==10 Tens<=0, Ovf<=1, else Tens<=t.
//    Go WAIT_REL; Done<=1 for exactly one cycle.
//  WAIT_REL: stay until debounced level is 1, then IDLE. Holding the button = one add.
//  Latency: press pulse in cycle k -> ONES k+1 -> TENS k+2 (Ones updated)
//    -> Tens updated and Done=1 in k+3; Busy=1 in k+1..until release.
//  Clr=1 (any state, priority over FSM actions): Ones,Tens,Ovf,Err,carry <= 0,
//    FSM <= WAIT_REL, Done<=0. Clr coincident with press: clear wins, no add.
//  Wrap: 99+1 -> 00 Ovf=1; 95+9 -> 04 Ovf=1. Ovf/Err cleared only by Clr/reset.
//  Digit/Cin changes after latching do not affect an add in progress.
//  Reset mid-operation (ONES/TENS): all state returns to reset values immediately.
// STRUCTURE
//  bcd_defs.vh (shared include): BCD_MAX=4'd9, BCD_TEN=5'd10, FSM state encodings
//    S_IDLE/S_ONES/S_TENS/S_WAIT_REL (2-bit).
//  Sub-module key_debounce(Clock, Resetn, Key_n, Level, Press): sync + filter +
//    edge detect, parameterised by DB_CYCLES/DB_W; reused for other buttons.
//  Top: FSM, operand regs, BCD digit adder/carry logic, sticky flags.
// TESTING (bench overrides DB_CYCLES=4, DB_W=3)
//  1 Reset, Digit=7 Cin=0, clean press -> Ones=7 Tens=0, Done one pulse 3 cycles after Press.
//  2 Then Digit=5 Cin=1 press -> Ones=3 Tens=1 (13), Ovf=0.
//  3 Add_n low for 2 cycles only, and 3-cycle bounce train -> totals unchanged, Done never high.
//  4 Digit=4'hC press -> Err=1, totals unchanged; Clr=1 one cycle -> Ones=Tens=0, Err=0.
//  5 Accumulate to 95, Digit=9 Cin=0 press -> Ones=4 Tens=0 Ovf=1; 99+Cin only -> 00 Ovf=1.
//  6 Hold Add_n low 1000 cycles -> exactly one add; Resetn=0 during TENS -> all outputs 0 same cycle.

Source files
------------

// File: rtl/bcd_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// bcd_accumulator_pkg
// Shared BCD constants, FSM state encoding and the digit-sum helper used by
// the BCD accumulator and its pushbutton front end.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_accumulator_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [4:0] BCD_TEN = 5'd10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ONES     = 2'd1,
    S_TENS     = 2'd2,
    S_WAIT_REL = 2'd3
  } state_e;

  // Raw 5-bit sum of a BCD digit, an operand digit and a carry-in (max 19)
  function automatic logic [4:0] bcd_digit_sum(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       c);
    return {1'b0, a} + {1'b0, b} + {4'b0000, c};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_accumulator_key_debounce.sv
// ---------------------------------------------------------------------------
// bcd_accumulator_key_debounce
// Two-flop synchronizer, stable-level debounce filter and press-edge detect
// for an active-low pushbutton. Reusable for any button on the board.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_accumulator_key_debounce #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 19
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic level_o,
  output logic press_o
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            level_d;
  logic            press_q;
  logic            press_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  // Filter: count while the synced input disagrees with the debounced level;
  // the level flips only after CNT_LAST+1 consecutive disagreeing cycles.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
    press_d = level_q & ~level_d;
  end

  // Synchronizer, debounce state and registered press pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/bcd_accumulator.sv
// ---------------------------------------------------------------------------
// bcd_accumulator
// Accumulates one BCD digit (plus optional carry-in) per debounced button
// press into a two-digit BCD running total with sticky overflow/error flags.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_accumulator
  import bcd_accumulator_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 19
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] digit_i,
  input  logic       cin_i,
  input  logic       add_ni,
  input  logic       clr_i,
  output logic [3:0] ones_o,
  output logic [3:0] tens_o,
  output logic       ovf_o,
  output logic       err_o,
  output logic       busy_o,
  output logic       done_o
);

  state_e     state_q;
  logic [3:0] opd_digit_q;
  logic       opd_cin_q;
  logic       carry_q;
  logic [3:0] ones_q;
  logic [3:0] tens_q;
  logic       ovf_q;
  logic       err_q;
  logic       done_q;

  logic       key_level;
  logic       key_press;
  logic [4:0] ones_sum;
  logic [3:0] ones_wrap;
  logic [3:0] tens_sum;

  bcd_accumulator_key_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_key (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .key_ni  (add_ni),
    .level_o (key_level),
    .press_o (key_press)
  );

  // Digit adders; wrap value is only used when the sum is 10..19, where the
  // modulo-16 subtraction of the low nibble yields the correct 0..9 result.
  always_comb begin
    ones_sum  = bcd_digit_sum(ones_q, opd_digit_q, opd_cin_q);
    ones_wrap = ones_sum[3:0] - BCD_TEN[3:0];
    tens_sum  = tens_q + {3'b000, carry_q};
  end

  // Control FSM with operand latch, totals and sticky flags; clear has priority
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      opd_digit_q <= 4'd0;
      opd_cin_q   <= 1'b0;
      carry_q     <= 1'b0;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clr_i) begin
        ones_q  <= 4'd0;
        tens_q  <= 4'd0;
        ovf_q   <= 1'b0;
        err_q   <= 1'b0;
        carry_q <= 1'b0;
        state_q <= S_WAIT_REL;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (key_press) begin
              if (digit_i > BCD_MAX) begin
                err_q   <= 1'b1;
                state_q <= S_WAIT_REL;
              end else begin
                opd_digit_q <= digit_i;
                opd_cin_q   <= cin_i;
                state_q     <= S_ONES;
              end
            end
          end
          S_ONES: begin
            if (ones_sum > {1'b0, BCD_MAX}) begin
              ones_q  <= ones_wrap;
              carry_q <= 1'b1;
            end else begin
              ones_q  <= ones_sum[3:0];
              carry_q <= 1'b0;
            end
            state_q <= S_TENS;
          end
          S_TENS: begin
            if (tens_sum == BCD_TEN[3:0]) begin
              tens_q <= 4'd0;
              ovf_q  <= 1'b1;
            end else begin
              tens_q <= tens_sum;
            end
            done_q  <= 1'b1;
            state_q <= S_WAIT_REL;
          end
          S_WAIT_REL: begin
            if (key_level) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ones_o = ones_q;
  assign tens_o = tens_q;
  assign ovf_o  = ovf_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_accumulator.sv
// ---------------------------------------------------------------------------
// tb_bcd_accumulator
// Directed, table-driven bench for bcd_accumulator with a short debounce.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bcd_accumulator;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit;
  logic       cin;
  logic       add_n;
  logic       clr;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       ovf;
  logic       err;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  int cyc        = 0;
  int done_cnt   = 0;
  int done_at    = 0;
  int busy_rise  = 0;
  int busy_rises = 0;
  logic busy_prev = 1'b0;

  typedef struct {
    bit         is_clr;
    logic [3:0] digit;
    logic       cin;
    logic [3:0] e_tens;
    logic [3:0] e_ones;
    logic       e_ovf;
    logic       e_err;
  } vec_t;

  vec_t vecs[27];

  bcd_accumulator #(
    .DB_CYCLES (4),
    .DB_W      (3)
  ) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .digit_i (digit),
    .cin_i   (cin),
    .add_ni  (add_n),
    .clr_i   (clr),
    .ones_o  (ones),
    .tens_o  (tens),
    .ovf_o   (ovf),
    .err_o   (err),
    .busy_o  (busy),
    .done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Track Done pulses and Busy rising edges, sampled mid-cycle
  always @(negedge clk) begin
    busy_prev <= busy;
    if (busy && !busy_prev) begin
      busy_rise  <= cyc;
      busy_rises <= busy_rises + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_at  <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold the button low for 'low' cycles, release, then wait for the FSM to go idle
  task automatic do_press(input int low, output bit ok);
    @(posedge clk); #1 add_n = 1'b0;
    repeat (low) @(posedge clk);
    #1 add_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit ok;
    int d0;
    int b0;

    rst_n = 1'b0;
    digit = 4'd0;
    cin   = 1'b0;
    add_n = 1'b1;
    clr   = 1'b0;

    vecs[0]  = '{1'b0, 4'd7,  1'b0, 4'd0, 4'd7, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd5,  1'b1, 4'd1, 4'd3, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'hC,  1'b0, 4'd1, 4'd3, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 4'd0,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++)
      vecs[4 + i] = '{1'b0, 4'd9, 1'b1, 4'(i + 1), 4'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'd5,  1'b0, 4'd9, 4'd5, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'd9,  1'b0, 4'd0, 4'd4, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 4'd0,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++)
      vecs[16 + i] = '{1'b0, 4'd9, 1'b1, 4'(i + 1), 4'd0, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 4'd9,  1'b0, 4'd9, 4'd9, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 4'd0,  1'b1, 4'd0, 4'd0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs", {20'd0, ones, tens, ovf, err, busy, done}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_outputs", {20'd0, ones, tens, ovf, err, busy, done}, 32'd0);

    for (int i = 0; i < 27; i++) begin
      if (i == 2) begin
        // Short glitch and a bounce train must never register as a press
        d0 = done_cnt;
        b0 = busy_rises;
        @(posedge clk); #1 add_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 add_n = 1'b1;
        repeat (3) begin
          repeat (3) @(posedge clk);
          #1 add_n = 1'b0;
          @(posedge clk);
          #1 add_n = 1'b1;
        end
        repeat (15) @(negedge clk);
        check("glitch_no_done", done_cnt - d0, 0);
        check("glitch_no_busy", busy_rises - b0, 0);
        check("glitch_total", {24'd0, tens, ones}, 32'h13);
      end

      digit = vecs[i].digit;
      cin   = vecs[i].cin;
      d0    = done_cnt;
      if (vecs[i].is_clr) begin
        do_clear();
        check($sformatf("v%0d_clr_idle", i), {31'd0, busy}, 0);
      end else begin
        do_press(10, ok);
        check($sformatf("v%0d_idle_timeout", i), {31'd0, ok}, 1);
        if (vecs[i].e_err && !err) begin
          check($sformatf("v%0d_err_set", i), {31'd0, err}, 1);
        end
        if (digit > 4'd9) begin
          check($sformatf("v%0d_err_no_done", i), done_cnt - d0, 0);
        end else begin
          check($sformatf("v%0d_done_count", i), done_cnt - d0, 1);
          check($sformatf("v%0d_done_delay", i), done_at - busy_rise, 2);
        end
      end
      check($sformatf("v%0d_total", i), {24'd0, tens, ones},
            {24'd0, vecs[i].e_tens, vecs[i].e_ones});
      check($sformatf("v%0d_flags", i), {30'd0, ovf, err},
            {30'd0, vecs[i].e_ovf, vecs[i].e_err});
    end

    // Long hold: exactly one add
    digit = 4'd3;
    cin   = 1'b0;
    d0    = done_cnt;
    do_press(1000, ok);
    check("hold_idle_timeout", {31'd0, ok}, 1);
    check("hold_done_count", done_cnt - d0, 1);
    check("hold_total", {24'd0, tens, ones}, 32'h03);

    // Operand changes after latching must not affect the add; reset lands in TENS
    digit = 4'd4;
    @(posedge clk); #1 add_n = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_busy_seen", {31'd0, ok}, 1);
    digit = 4'd1;
    @(posedge clk); #1;
    check("tens_state_ones", {28'd0, ones}, 32'd7);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {20'd0, ones, tens, ovf, err, busy, done}, 32'd0);
    add_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("after_reset_quiet", {20'd0, ones, tens, ovf, err, busy, done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
